// File: rtl/ilog2_pipe.sv
// Two-stage pipelined floor(log2(v)) with valid/ready on both sides and a sideband tag.
// Define ILOG2_STATS_EN to add saturating result/zero counters (stat_clr, stat_total, stat_zero).
module ilog2_pipe #(
  parameter  int DATA_W = 32,
  parameter  int TAG_W  = 8,
  localparam int LOG_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG_W-1:0]  out_log2,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
`ifdef ILOG2_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_total,
  output logic [31:0]       stat_zero
`endif
);

  localparam int NB = DATA_W / 8;

  function automatic logic [2:0] byte_log2(input logic [7:0] b);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = 3'(i);
    end
    return r;
  endfunction

  logic                  ready1, ready2, in_fire;

  logic                  s1_valid_q, s1_valid_d;
  logic [NB-1:0]         s1_mask_q, s1_mask_d;
  logic [NB-1:0][2:0]    s1_blog_q, s1_blog_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
  logic                  s1_zero_q, s1_zero_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [LOG_W-1:0]      s2_log_q, s2_log_d;
  logic                  s2_zero_q, s2_zero_d;
  logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;
  logic [LOG_W-1:0]      sel_log;

  assign ready2   = !s2_valid_q || out_ready;
  assign ready1   = !s1_valid_q || ready2;
  assign in_ready = ready1;
  assign in_fire  = in_valid && ready1;

  // Stage 1: per-byte nonzero mask and byte-local log2; data only captured on an accepted word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    s1_valid_d = s1_valid_q;
    s1_mask_d  = s1_mask_q;
    s1_blog_d  = s1_blog_q;
    s1_tag_d   = s1_tag_q;
    s1_zero_d  = s1_zero_q;
    if (ready1) s1_valid_d = in_valid;
    if (in_fire) begin
      for (int b = 0; b < NB; b++) begin
        s1_mask_d[b] = |in_data[8*b +: 8];
        s1_blog_d[b] = byte_log2(in_data[8*b +: 8]);
      end
      s1_tag_d  = in_tag;
      s1_zero_d = (in_data == '0);
    end
  end

  // Highest nonzero byte wins; an all-zero mask leaves the result at 0.
  always_comb begin
    sel_log = '0;
    for (int b = 0; b < NB; b++) begin
      if (s1_mask_q[b]) sel_log = LOG_W'(b * 8 + int'(s1_blog_q[b]));
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_log_d   = s2_log_q;
    s2_zero_d  = s2_zero_q;
    s2_tag_d   = s2_tag_q;
    if (ready2) s2_valid_d = s1_valid_q;
    if (ready2 && s1_valid_q) begin
      s2_log_d  = sel_log;
      s2_zero_d = s1_zero_q;
      s2_tag_d  = s1_tag_q;
    end
  end

  // NOTE: data registers are reset along with the valids so outputs are never X after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mask_q  <= '0;
      s1_blog_q  <= '0;
      s1_tag_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_log_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_mask_q  <= s1_mask_d;
      s1_blog_q  <= s1_blog_d;
      s1_tag_q   <= s1_tag_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_log_q   <= s2_log_d;
      s2_zero_q  <= s2_zero_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_log2  = s2_log_q;
  assign out_zero  = s2_zero_q;
  assign out_tag   = s2_tag_q;

`ifdef ILOG2_STATS_EN
  logic [31:0] tot_q, tot_d, zer_q, zer_d;
  logic        out_fire;

  assign out_fire = s2_valid_q && out_ready;

  // Saturating counters; a clear wins over a coincident increment.
  always_comb begin
    tot_d = tot_q;
    zer_d = zer_q;
    if (stat_clr) begin
      tot_d = '0;
      zer_d = '0;
    end else if (out_fire) begin
      if (tot_q != 32'hFFFF_FFFF) tot_d = tot_q + 32'd1;
      if (s2_zero_q && zer_q != 32'hFFFF_FFFF) zer_d = zer_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tot_q <= '0;
      zer_q <= '0;
    end else begin
      tot_q <= tot_d;
      zer_q <= zer_d;
    end
  end

  assign stat_total = tot_q;
  assign stat_zero  = zer_q;
`endif

endmodule

// File: tb/tb_ilog2_pipe.sv
// Self-checking bench for ilog2_pipe: queue-based reference model, directed and random stimulus.
module tb_ilog2_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data;
  logic [7:0]  in_tag, out_tag;
  logic [4:0]  out_log2;

  logic        v64_valid, r64_ready, o64_valid, o64_zero;
  logic [63:0] v64_data;
  logic [7:0]  o64_tag;
  logic [5:0]  o64_log2;
  logic        v8_valid, r8_ready, o8_valid, o8_zero;
  logic [7:0]  v8_data;
  logic [7:0]  o8_tag;
  logic [2:0]  o8_log2;

`ifdef ILOG2_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_total, stat_zero, s64_t, s64_z, s8_t, s8_z;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int out_cnt  = 0;

  typedef struct {
    int        lg;
    bit        zero;
    logic [7:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   got_log[$];
  bit   got_zero[$];
  logic [7:0] got_tag[$];

  ilog2_pipe #(.DATA_W(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_log2(out_log2), .out_zero(out_zero), .out_tag(out_tag)
`ifdef ILOG2_STATS_EN
    , .stat_clr(stat_clr), .stat_total(stat_total), .stat_zero(stat_zero)
`endif
  );

  ilog2_pipe #(.DATA_W(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64_valid), .in_ready(r64_ready),
    .in_data(v64_data), .in_tag(8'h64), .out_valid(o64_valid), .out_ready(1'b1),
    .out_log2(o64_log2), .out_zero(o64_zero), .out_tag(o64_tag)
`ifdef ILOG2_STATS_EN
    , .stat_clr(1'b0), .stat_total(s64_t), .stat_zero(s64_z)
`endif
  );

  ilog2_pipe #(.DATA_W(8), .TAG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_valid), .in_ready(r8_ready),
    .in_data(v8_data), .in_tag(8'h08), .out_valid(o8_valid), .out_ready(1'b1),
    .out_log2(o8_log2), .out_zero(o8_zero), .out_tag(o8_tag)
`ifdef ILOG2_STATS_EN
    , .stat_clr(1'b0), .stat_total(s8_t), .stat_zero(s8_z)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan bits from the top; the first set bit is floor(log2(v)).
  function automatic int ref_log2(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Compare process: scoreboard on every output fire, stability while stalled.
  bit         have_prev = 0;
  logic [4:0] prev_log;
  logic       prev_zero;
  logic [7:0] prev_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 0;
    end else begin
      if (have_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_log", out_log2, prev_log);
        check("stall_zero", out_zero, prev_zero);
        check("stall_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_log2", out_log2, e.lg);
          check("out_zero", out_zero, e.zero);
          check("out_tag", out_tag, e.tag);
        end
        got_log.push_back(int'(out_log2));
        got_zero.push_back(out_zero);
        got_tag.push_back(out_tag);
        out_cnt++;
      end
      have_prev = out_valid && !out_ready;
      prev_log  = out_log2;
      prev_zero = out_zero;
      prev_tag  = out_tag;
      if (in_valid && in_ready) begin
        exp_t e;
        e.lg   = ref_log2({32'h0, in_data}, 32);
        e.zero = (in_data == 0);
        e.tag  = in_tag;
        exp_q.push_back(e);
      end
    end
  end

  // Present a word and hold it until accepted; leaves in_valid high on return.
  task automatic send(input logic [31:0] v, input logic [7:0] t);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_tag   = t;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, c0;
    logic [31:0] dir_v [6] = '{32'h1, 32'h2, 32'h3, 32'h8000_0000, 32'h00FF_0000, 32'h0};
    int          dir_l [6] = '{0, 1, 1, 31, 23, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    v64_valid = 1'b0; v64_data = '0; v8_valid = 1'b0; v8_data = '0;
`ifdef ILOG2_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Model pins
    check("ref_1", ref_log2(64'h1, 32), 0);
    check("ref_msb32", ref_log2(64'h8000_0000, 32), 31);
    check("ref_ff0000", ref_log2(64'h00FF_0000, 32), 23);
    check("ref_zero", ref_log2(64'h0, 32), 0);

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_log2", out_log2, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed sequence, back-to-back
    got_log.delete(); got_zero.delete(); got_tag.delete();
    for (int i = 0; i < 6; i++) send(dir_v[i], 8'(8'hA0 + i));
    in_valid = 1'b0;
    drain();
    check("dir_count", got_log.size(), 6);
    for (int i = 0; i < 6 && i < got_log.size(); i++) begin
      check($sformatf("dir_log_%0d", i), got_log[i], dir_l[i]);
      check($sformatf("dir_zero_%0d", i), got_zero[i], i == 5);
      check($sformatf("dir_tag_%0d", i), got_tag[i], 8'hA0 + i);
    end

    // Other widths, two-cycle latency
    v64_valid = 1'b1; v64_data = 64'h8000_0000_0000_0000;
    v8_valid = 1'b1; v8_data = 8'hFF;
    @(posedge clk); #1;
    v64_data = 64'h0000_0001_0000_0000; v8_valid = 1'b0;
    @(posedge clk); #1;
    v64_valid = 1'b0;
    @(negedge clk);
    check("w64_valid", o64_valid, 1);
    check("w64_msb", o64_log2, 63);
    check("w8_valid", o8_valid, 1);
    check("w8_ff", o8_log2, 7);
    check("w8_zero", o8_zero, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w64_bit32", o64_log2, 32);
    check("w64_tag", o64_tag, 8'h64);
    check("w8_drained", o8_valid, 0);
    @(posedge clk); #1;

    // Backpressure
    base = out_cnt;
    out_ready = 1'b0;
    send(32'h10, 8'h01);
    send(32'h100, 8'h02);
    in_data = 32'h1000; in_tag = 8'h03;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h1000, 8'h03);
    send(32'h0, 8'h04);
    send(32'hFFFF_FFFF, 8'h05);
    in_valid = 1'b0;
    drain();
    check("bp_count", out_cnt - base, 5);

    // Full-rate random stream
    base = out_cnt;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      send(v, 8'($urandom));
    end
    check("rand_no_bubble_in", cyc - c0, 100);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rand_out_count", out_cnt - base, 100);

    // Reset with both stages full and stalled
    out_ready = 1'b0;
    send(32'h55, 8'h11);
    send(32'h66, 8'h12);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    base = out_cnt;
    repeat (3) @(negedge clk);
    check("rst_no_stale", out_cnt - base, 0);
    @(posedge clk); #1;

`ifdef ILOG2_STATS_EN
    for (int i = 0; i < 10; i++) send((i % 3 == 2) ? 32'h0 : 32'(i + 1), 8'(i));
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    check("stat_total", stat_total, 10);
    check("stat_zero", stat_zero, 3);
    send(32'h0, 8'hEE);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    check("clr_fire_valid", out_valid, 1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("clr_total", stat_total, 0);
    check("clr_zero", stat_zero, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
